uart_tx_param: RTL
==================

Name: uart_tx_param

Overview:
Parametrised UART transmitter, successor to the fixed 8-bit, 4-rate transmitter in the Day-29 UART core. It adds a runtime 16-bit baud divisor, selectable parity (none/even/odd), 1 or 2 stop bits, and a configurable-depth transmit FIFO with valid/ready input. It sits between the host-side write path and the serial tx pin of the full-duplex UART IP.

Parameters:
DATA_W, 8, data bits per frame (legal 5..9), sent LSB first
FIFO_DEPTH, 4, TX FIFO entries (power of 2, >=2)
CNT_W, $clog2(FIFO_DEPTH)+1, width of fifo_count (derived, not overridden)

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
tx_en  input  1  frame-start enable; low blocks new frames, current frame completes
baud_div  input  16  clocks per bit; values 0 and 1 treated as 2
parity_mode  input  2  00 none, 01 even, 10 odd, 11 none
stop2  input  1  0 = one stop bit, 1 = two stop bits
s_valid  input  1  write request
s_data  input  DATA_W  word to transmit
s_ready  output  1  FIFO not full
tx  output  1  serial line, idle high
busy  output  1  frame in progress
done  output  1  one-cycle pulse at end of each frame
fifo_count  output  CNT_W  words held in FIFO

Behaviour:
- Reset (async, rstn low): tx=1, busy=0, done=0, FIFO emptied, fifo_count=0, s_ready=1, FSM=IDLE, baud counter=0. Reset mid-frame: tx returns high immediately; the partial frame is lost.
- FIFO: write on a rising edge when s_valid && s_ready. s_ready = (fifo_count != FIFO_DEPTH), derived from registered state. Pop happens only in the FSM load step. A simultaneous push and pop leaves fifo_count unchanged. Pointers wrap modulo FIFO_DEPTH. A write while full is ignored with no corruption.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: if tx_en && FIFO non-empty, pop the head word into the shift register. Latch baud_div, parity_mode and stop2 into frame-config registers; config changes mid-frame have no effect. Go to START with tx=0 and busy=1.
- Bit timing: every bit lasts exactly eff_div = max(baud_div, 2) clocks, using a down-counter reloaded at each bit boundary.
- START: 1 bit at 0, then DATA.
- DATA: DATA_W bits, LSB first. Then PARITY if the latched mode is 01/10, else STOP.
- PARITY: even mode sends XOR of the data bits; odd mode sends its inverse.
- STOP: tx=1 for 1 or 2 bits.
- End of last stop bit: done=1 for exactly one cycle. If tx_en && FIFO non-empty on that edge, pop and enter START directly, with busy staying 1 and no idle gap. Otherwise go to IDLE with busy=0 and tx=1.
- Frame length: (1 + DATA_W + P + S) * eff_div clocks, where P∈{0,1} and S∈{1,2}.
- Latency: word accepted at edge E; the FIFO is non-empty after E; tx falls after edge E+1 when idle and tx_en=1.
- tx_en low during a frame: the frame finishes normally, then the FSM waits in IDLE.
- tx, busy and done are registered outputs with no combinational path from inputs.

Test Plan:
1. Reset, DATA_W=8, baud_div=4, parity_mode=01, stop2=0, write 0xA9 -> tx falls 2 edges after accept. Bit sequence is 0,1,0,0,1,0,1,0,1, parity 0, stop 1, each bit 4 clocks, for 44 clocks total. done pulses once; busy returns to 0.
2. parity_mode=10, stop2=1, baud_div=3, write 0xF7 -> data 1,1,1,0,1,1,1,1, parity 0, two stop bits, for a 36-clock frame.
3. Fill the FIFO with 5 writes back-to-back with FIFO_DEPTH=4 and tx_en=0 -> fifo_count reaches 4, s_ready goes low, the 5th write is dropped. Raising tx_en sends 4 frames back-to-back with no gap between stop and start. done pulses 4 times; busy stays high throughout.
4. baud_div=0, parity_mode=00, write 0x00 -> bits last 2 clocks and there is no parity bit, giving a 20-clock frame.
5. Change baud_div from 4 to 8 and parity_mode mid-frame -> the current frame is unaffected and the next frame uses the new values.
6. Assert rstn=0 in the middle of the DATA state with 2 words queued -> tx=1, busy=0 and fifo_count=0 immediately. After release, no frame starts until a new write.

Source files
------------

// File: rtl/uart_tx_param.sv
// uart_tx_param
//   UART transmitter with a runtime baud divisor, optional even/odd parity,
//   1 or 2 stop bits and a small transmit FIFO on a valid/ready write port.
//   Frame config (divisor, parity, stop bits) is captured when a word is
//   popped, so changing the inputs mid-frame only affects later frames.
//
// Ports
//   clk          system clock
//   rstn         asynchronous active-low reset
//   tx_en        allows new frames to start; a frame in flight always finishes
//   baud_div     clocks per bit (0 and 1 behave as 2)
//   parity_mode  00/11 none, 01 even, 10 odd
//   stop2        0 = one stop bit, 1 = two stop bits
//   s_valid      write request
//   s_data       word to send, LSB first
//   s_ready      FIFO has room
//   tx           serial output, idle high (registered)
//   busy         frame in progress (registered)
//   done         one-cycle pulse after the last stop bit (registered)
//   fifo_count   words waiting in the FIFO
//
// state    | meaning
// ---------+---------------------------------------------
// S_IDLE   | line high, waiting for tx_en and a queued word
// S_START  | start bit (low)
// S_DATA   | DATA_W data bits, LSB first
// S_PARITY | parity bit (only when parity enabled)
// S_STOP   | one or two stop bits (high)
module uart_tx_param #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              tx_en,
  input  logic [15:0]       baud_div,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // FIFO
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic              push;
  logic              pop;
  logic              fifo_empty;

  // Transmit engine
  state_t            state_q;
  logic [15:0]       baud_cnt_q;
  logic [15:0]       div_q;
  logic [DATA_W-1:0] shreg_q;
  logic [BIT_W-1:0]  bit_cnt_q;
  logic              par_q;
  logic              par_en_q;
  logic              par_odd_q;
  logic              stop2_q;
  logic              stop_left_q;
  logic              tx_q;
  logic              busy_q;
  logic              done_q;

  logic [15:0]       eff_div;
  logic              bit_end;
  logic              frame_end;

  assign eff_div    = (baud_div < 16'd2) ? 16'd2 : baud_div;
  assign fifo_empty = (count_q == '0);
  assign s_ready    = (count_q != FULL_CNT);
  assign push       = s_valid && s_ready;
  assign bit_end    = (baud_cnt_q == '0);
  assign frame_end  = (state_q == S_STOP) && bit_end && !stop_left_q;
  // The only pop point: from idle, or straight out of the last stop bit so
  // consecutive frames run with no idle gap.
  assign pop        = tx_en && !fifo_empty && ((state_q == S_IDLE) || frame_end);
  assign count_d    = count_q + CNT_W'(push) - CNT_W'(pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      baud_cnt_q  <= '0;
      div_q       <= 16'd2;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      par_q       <= 1'b0;
      par_en_q    <= 1'b0;
      par_odd_q   <= 1'b0;
      stop2_q     <= 1'b0;
      stop_left_q <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (pop) begin
        shreg_q    <= mem_q[rd_ptr_q];
        par_q      <= ^mem_q[rd_ptr_q];
        div_q      <= eff_div;
        baud_cnt_q <= eff_div - 16'd1;
        par_en_q   <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
        par_odd_q  <= (parity_mode == 2'b10);
        stop2_q    <= stop2;
        bit_cnt_q  <= '0;
        tx_q       <= 1'b0;
        busy_q     <= 1'b1;
        state_q    <= S_START;
        // Back-to-back case still owes the end-of-frame pulse.
        done_q     <= frame_end;
      end else if (state_q != S_IDLE) begin
        if (!bit_end) begin
          baud_cnt_q <= baud_cnt_q - 16'd1;
        end else begin
          baud_cnt_q <= div_q - 16'd1;
          case (state_q)
            S_START: begin
              state_q <= S_DATA;
              tx_q    <= shreg_q[0];
              shreg_q <= shreg_q >> 1;
            end
            S_DATA: begin
              if (bit_cnt_q == LAST_BIT) begin
                if (par_en_q) begin
                  state_q <= S_PARITY;
                  tx_q    <= par_q ^ par_odd_q;
                end else begin
                  state_q     <= S_STOP;
                  tx_q        <= 1'b1;
                  stop_left_q <= stop2_q;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
                tx_q      <= shreg_q[0];
                shreg_q   <= shreg_q >> 1;
              end
            end
            S_PARITY: begin
              state_q     <= S_STOP;
              tx_q        <= 1'b1;
              stop_left_q <= stop2_q;
            end
            S_STOP: begin
              if (stop_left_q) begin
                stop_left_q <= 1'b0;
              end else begin
                state_q    <= S_IDLE;
                tx_q       <= 1'b1;
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
                baud_cnt_q <= '0;
              end
            end
            default: begin
              state_q <= S_IDLE;
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fifo_count = count_q;

endmodule
